// File: rtl/ltssm_pkg.sv
// Shared types and constants for the LTSSM Detect sub-state machine.
package ltssm_pkg;

  typedef enum logic [2:0] {
    QUIET      = 3'd0,
    ACT_REQ    = 3'd1,
    ACT_WAIT   = 3'd2,
    RETRY_WAIT = 3'd3,
    POLLING    = 3'd4
  } detect_state_e;

  localparam logic [2:0] RXSTAT_RX_PRESENT = 3'b011;
  localparam logic [1:0] PD_P1             = 2'b10;

  function automatic logic rx_present(input logic [2:0] rx_status);
    return rx_status == RXSTAT_RX_PRESENT;
  endfunction

endpackage

// File: rtl/ltssm_lane_resp.sv
// Per-lane capture of the PIPE receiver-detect response and its result.
// The next-state values are exported so a response arriving on the last wait cycle still counts.
module ltssm_lane_resp
  import ltssm_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       capture_en_i,
  input  logic       phy_status_i,
  input  logic [2:0] rx_status_i,
  output logic       resp_next_o,
  output logic       det_next_o
);

  logic resp_q, resp_d;
  logic det_q, det_d;

  // Only the first PhyStatus per request is taken; later duplicates are dropped.
  always_comb begin
    resp_d = resp_q;
    det_d  = det_q;
    if (clear_i) begin
      resp_d = 1'b0;
      det_d  = 1'b0;
    end else if (capture_en_i && phy_status_i && !resp_q) begin
      resp_d = 1'b1;
      det_d  = rx_present(rx_status_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_q <= 1'b0;
      det_q  <= 1'b0;
    end else begin
      resp_q <= resp_d;
      det_q  <= det_d;
    end
  end

  assign resp_next_o = resp_d;
  assign det_next_o  = det_d;

endmodule

// File: rtl/ltssm_detect.sv
// LTSSM Detect sub-state machine: drives the 12 ms detect timer, sequences PIPE receiver detection
// with one retry and hands off to Polling. Optional macro LTSSM_EIDLE_EXIT_EN adds electrical-idle exit from QUIET.
module ltssm_detect
  import ltssm_pkg::*;
#(
  parameter int NUM_LANES           = 1,
  parameter int RESP_TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   link_en_i,
  input  logic                   restart_i,
  input  logic                   timeout_i,
  input  logic [NUM_LANES-1:0]   phy_status_i,
  input  logic [3*NUM_LANES-1:0] rx_status_i,
  input  logic [NUM_LANES-1:0]   rx_elec_idle_i,
  output logic                   en_timer_o,
  output logic                   tx_detect_rx_o,
  output logic                   tx_elec_idle_o,
  output logic [1:0]             power_down_o,
  output logic [NUM_LANES-1:0]   lanes_detected_o,
  output logic                   detect_done_o,
  output logic [2:0]             state_o
);

  localparam int              CNT_W    = $clog2(RESP_TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESP_TIMEOUT_CYCLES);

  detect_state_e          state_q, state_d;
  logic                   en_timer_q, en_timer_d;
  logic                   tx_detect_rx_q, tx_detect_rx_d;
  logic                   tx_elec_idle_q;
  logic [1:0]             power_down_q;
  logic [NUM_LANES-1:0]   lanes_q, lanes_d;
  logic                   done_q, done_d;
  logic [NUM_LANES-1:0]   first_mask_q, first_mask_d;
  logic                   second_q, second_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_LANES-1:0]   resp_next;
  logic [NUM_LANES-1:0]   det_next;
  logic                   lane_clear;
  logic                   lane_capture;
  logic                   timer_fired;
  logic                   attempt_done;
  logic                   eidle_exit;

  assign lane_clear   = (state_q == ACT_REQ);
  assign lane_capture = (state_q == ACT_WAIT);

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      ltssm_lane_resp u_lane_resp (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (lane_clear),
        .capture_en_i (lane_capture),
        .phy_status_i (phy_status_i[gi]),
        .rx_status_i  (rx_status_i[3*gi +: 3]),
        .resp_next_o  (resp_next[gi]),
        .det_next_o   (det_next[gi])
      );
    end
  endgenerate

`ifdef LTSSM_EIDLE_EXIT_EN
  logic [NUM_LANES-1:0] eidle_s1_q;
  logic [NUM_LANES-1:0] eidle_s2_q;

  // A lane must be out of electrical idle on two consecutive samples to count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      eidle_s1_q <= '0;
      eidle_s2_q <= '0;
    end else begin
      eidle_s1_q <= ~rx_elec_idle_i;
      eidle_s2_q <= eidle_s1_q;
    end
  end

  assign eidle_exit = |(eidle_s1_q & eidle_s2_q);
`else
  logic unused_elec_idle;
  assign unused_elec_idle = ^rx_elec_idle_i;
  assign eidle_exit       = 1'b0;
`endif

  // The timer output is a free-running pulse; it only means something while we enable it.
  assign timer_fired  = timeout_i && en_timer_q;
  assign attempt_done = (&resp_next) || (cnt_q <= CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    first_mask_d = first_mask_q;
    second_d     = second_q;
    cnt_d        = cnt_q;

    case (state_q)
      QUIET: begin
        second_d = 1'b0;
        if (link_en_i && (timer_fired || eidle_exit)) begin
          state_d = ACT_REQ;
        end
      end
      ACT_REQ: begin
        cnt_d   = CNT_LOAD;
        state_d = ACT_WAIT;
      end
      ACT_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (attempt_done) begin
          if (&det_next) begin
            state_d = POLLING;
          end else if (!(|det_next)) begin
            state_d = QUIET;
          end else if (!second_q) begin
            state_d      = RETRY_WAIT;
            first_mask_d = det_next;
          end else if (det_next == first_mask_q) begin
            state_d = POLLING;
          end else begin
            state_d = QUIET;
          end
        end
      end
      RETRY_WAIT: begin
        if (timer_fired) begin
          state_d  = ACT_REQ;
          second_d = 1'b1;
        end
      end
      POLLING: begin
        if (restart_i) begin
          state_d = QUIET;
        end
      end
      default: state_d = QUIET;
    endcase

    // Once the link is handed to Polling, the top level owns link enable.
    if (!link_en_i && (state_q != POLLING)) begin
      state_d = QUIET;
    end

    lanes_d = '0;
    if (state_d == POLLING) begin
      lanes_d = (state_q == POLLING) ? lanes_q : det_next;
    end

    // Timer held off on the entry cycle of each timed wait so it restarts from zero.
    en_timer_d     = link_en_i && (state_q == state_d) &&
                     ((state_d == QUIET) || (state_d == RETRY_WAIT));
    tx_detect_rx_d = (state_d == ACT_REQ) || (state_d == ACT_WAIT);
    done_d         = (state_d == POLLING);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= QUIET;
      en_timer_q     <= 1'b0;
      tx_detect_rx_q <= 1'b0;
      tx_elec_idle_q <= 1'b1;
      power_down_q   <= PD_P1;
      lanes_q        <= '0;
      done_q         <= 1'b0;
      first_mask_q   <= '0;
      second_q       <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      en_timer_q     <= en_timer_d;
      tx_detect_rx_q <= tx_detect_rx_d;
      tx_elec_idle_q <= 1'b1;
      power_down_q   <= PD_P1;
      lanes_q        <= lanes_d;
      done_q         <= done_d;
      first_mask_q   <= first_mask_d;
      second_q       <= second_d;
      cnt_q          <= cnt_d;
    end
  end

  assign en_timer_o       = en_timer_q;
  assign tx_detect_rx_o   = tx_detect_rx_q;
  assign tx_elec_idle_o   = tx_elec_idle_q;
  assign power_down_o     = power_down_q;
  assign lanes_detected_o = lanes_q;
  assign detect_done_o    = done_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_ltssm_detect.sv
// Directed bench for ltssm_detect: a 1-lane and a 4-lane instance, hand-computed expectations.
module tb_ltssm_detect;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Single-lane instance
  logic        link_en_a, restart_a, timeout_a, phy_a, eidle_a;
  logic [2:0]  rx_a;
  logic        en_a, tx_a, txei_a, lanes_a, done_a;
  logic [1:0]  pd_a;
  logic [2:0]  state_a;

  // Four-lane instance
  logic        link_en_b, restart_b, timeout_b;
  logic [3:0]  phy_b, eidle_b;
  logic [11:0] rx_b;
  logic        en_b, tx_b, txei_b, done_b;
  logic [3:0]  lanes_b;
  logic [1:0]  pd_b;
  logic [2:0]  state_b;

  int n_vec  = 0;
  int n_miss = 0;

  ltssm_detect #(.NUM_LANES(1), .RESP_TIMEOUT_CYCLES(1024)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .link_en_i(link_en_a), .restart_i(restart_a),
    .timeout_i(timeout_a), .phy_status_i(phy_a), .rx_status_i(rx_a),
    .rx_elec_idle_i(eidle_a), .en_timer_o(en_a), .tx_detect_rx_o(tx_a),
    .tx_elec_idle_o(txei_a), .power_down_o(pd_a), .lanes_detected_o(lanes_a),
    .detect_done_o(done_a), .state_o(state_a)
  );

  ltssm_detect #(.NUM_LANES(4), .RESP_TIMEOUT_CYCLES(1024)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .link_en_i(link_en_b), .restart_i(restart_b),
    .timeout_i(timeout_b), .phy_status_i(phy_b), .rx_status_i(rx_b),
    .rx_elec_idle_i(eidle_b), .en_timer_o(en_b), .tx_detect_rx_o(tx_b),
    .tx_elec_idle_o(txei_b), .power_down_o(pd_b), .lanes_detected_o(lanes_b),
    .detect_done_o(done_b), .state_o(state_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    link_en_a = 1'b1; restart_a = 1'b0; timeout_a = 1'b0; phy_a = 1'b0; rx_a = 3'b000; eidle_a = 1'b1;
    link_en_b = 1'b1; restart_b = 1'b0; timeout_b = 1'b0; phy_b = 4'h0; rx_b = 12'h000; eidle_b = 4'hF;
    repeat (3) tick();
    n_vec++;
    if ({state_a, en_a, tx_a, txei_a, pd_a, lanes_a, done_a} !== {3'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0}) begin
      n_miss++;
      $display("FAIL reset_a: got %b expected %b", {state_a, en_a, tx_a, txei_a, pd_a, lanes_a, done_a},
               {3'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0});
    end
    n_vec++;
    if ({state_b, en_b, tx_b, txei_b, pd_b, lanes_b, done_b} !== {3'd0, 1'b0, 1'b0, 1'b1, 2'b10, 4'h0, 1'b0}) begin
      n_miss++;
      $display("FAIL reset_b: got %b expected %b", {state_b, en_b, tx_b, txei_b, pd_b, lanes_b, done_b},
               {3'd0, 1'b0, 1'b0, 1'b1, 2'b10, 4'h0, 1'b0});
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if ({state_a, en_a, state_b, en_b} !== {3'd0, 1'b1, 3'd0, 1'b1}) begin
      n_miss++;
      $display("FAIL timer_on_after_reset: got %b expected %b", {state_a, en_a, state_b, en_b},
               {3'd0, 1'b1, 3'd0, 1'b1});
    end
  endtask

  task automatic test_detect_present();
    repeat (4) tick();
    timeout_a = 1'b1; tick(); timeout_a = 1'b0;
    n_vec++;
    if ({state_a, tx_a, en_a} !== {3'd1, 1'b1, 1'b0}) begin
      n_miss++;
      $display("FAIL t1_act_req: got %b expected %b", {state_a, tx_a, en_a}, {3'd1, 1'b1, 1'b0});
    end
    tick();
    n_vec++;
    if ({state_a, tx_a} !== {3'd2, 1'b1}) begin
      n_miss++;
      $display("FAIL t1_act_wait: got %b expected %b", {state_a, tx_a}, {3'd2, 1'b1});
    end
    tick();
    phy_a = 1'b1; rx_a = 3'b011; tick(); phy_a = 1'b0; rx_a = 3'b000;
    n_vec++;
    if ({state_a, tx_a, en_a, done_a, lanes_a} !== {3'd4, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_miss++;
      $display("FAIL t1_polling: got %b expected %b", {state_a, tx_a, en_a, done_a, lanes_a},
               {3'd4, 1'b0, 1'b0, 1'b1, 1'b1});
    end
    tick();
    n_vec++;
    if ({state_a, txei_a, done_a, lanes_a} !== {3'd4, 1'b1, 1'b1, 1'b1}) begin
      n_miss++;
      $display("FAIL t1_polling_hold: got %b expected %b", {state_a, txei_a, done_a, lanes_a},
               {3'd4, 1'b1, 1'b1, 1'b1});
    end
    restart_a = 1'b1; tick(); restart_a = 1'b0;
    n_vec++;
    if ({state_a, en_a, done_a, lanes_a} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_miss++;
      $display("FAIL t1_restart: got %b expected %b", {state_a, en_a, done_a, lanes_a}, {3'd0, 1'b0, 1'b0, 1'b0});
    end
    tick();
    n_vec++;
    if ({state_a, en_a} !== {3'd0, 1'b1}) begin
      n_miss++;
      $display("FAIL t1_timer_reenable: got %b expected %b", {state_a, en_a}, {3'd0, 1'b1});
    end
  endtask

  task automatic test_detect_absent();
    timeout_a = 1'b1; tick(); timeout_a = 1'b0;
    tick();
    phy_a = 1'b1; rx_a = 3'b000; tick(); phy_a = 1'b0;
    n_vec++;
    if ({state_a, tx_a, en_a, done_a} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_miss++;
      $display("FAIL t2_back_to_quiet: got %b expected %b", {state_a, tx_a, en_a, done_a}, {3'd0, 1'b0, 1'b0, 1'b0});
    end
    // timeout while the timer is still held off must be ignored
    timeout_a = 1'b1; tick(); timeout_a = 1'b0;
    n_vec++;
    if ({state_a, en_a} !== {3'd0, 1'b1}) begin
      n_miss++;
      $display("FAIL t2_timeout_ignored: got %b expected %b", {state_a, en_a}, {3'd0, 1'b1});
    end
    timeout_a = 1'b1; tick(); timeout_a = 1'b0;
    n_vec++;
    if ({state_a, tx_a, en_a} !== {3'd1, 1'b1, 1'b0}) begin
      n_miss++;
      $display("FAIL t2_second_act_req: got %b expected %b", {state_a, tx_a, en_a}, {3'd1, 1'b1, 1'b0});
    end
  endtask

  task automatic test_resp_timeout();
    tick();
    repeat (1023) tick();
    n_vec++;
    if ({state_a, tx_a} !== {3'd2, 1'b1}) begin
      n_miss++;
      $display("FAIL t4_still_waiting: got %b expected %b", {state_a, tx_a}, {3'd2, 1'b1});
    end
    tick();
    n_vec++;
    if ({state_a, tx_a, en_a, done_a} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_miss++;
      $display("FAIL t4_expired: got %b expected %b", {state_a, tx_a, en_a, done_a}, {3'd0, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_link_drop();
    tick();
    timeout_a = 1'b1; tick(); timeout_a = 1'b0;
    tick();
    n_vec++;
    if (state_a !== 3'd2) begin
      n_miss++;
      $display("FAIL t5_in_wait: got %0d expected %0d", state_a, 2);
    end
    link_en_a = 1'b0; tick();
    n_vec++;
    if ({state_a, tx_a, en_a} !== {3'd0, 1'b0, 1'b0}) begin
      n_miss++;
      $display("FAIL t5_link_drop: got %b expected %b", {state_a, tx_a, en_a}, {3'd0, 1'b0, 1'b0});
    end
    phy_a = 1'b1; rx_a = 3'b011; timeout_a = 1'b1; tick();
    phy_a = 1'b0; rx_a = 3'b000; timeout_a = 1'b0;
    n_vec++;
    if ({state_a, tx_a, en_a, done_a, lanes_a} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_miss++;
      $display("FAIL t5_late_phy: got %b expected %b", {state_a, tx_a, en_a, done_a, lanes_a},
               {3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    link_en_a = 1'b1; tick();
    n_vec++;
    if ({state_a, en_a} !== {3'd0, 1'b1}) begin
      n_miss++;
      $display("FAIL t5_link_back: got %b expected %b", {state_a, en_a}, {3'd0, 1'b1});
    end
  endtask

  task automatic test_multilane();
    timeout_b = 1'b1; tick(); timeout_b = 1'b0;
    tick();
    phy_b = 4'b0011; rx_b = {3'b000, 3'b000, 3'b011, 3'b011}; tick();
    n_vec++;
    if ({state_b, tx_b} !== {3'd2, 1'b1}) begin
      n_miss++;
      $display("FAIL t3_partial_wait: got %b expected %b", {state_b, tx_b}, {3'd2, 1'b1});
    end
    // lane 0 repeats with "absent": first response must win
    phy_b = 4'b1101; rx_b = {3'b000, 3'b000, 3'b011, 3'b000}; tick();
    phy_b = 4'h0; rx_b = 12'h000;
    n_vec++;
    if ({state_b, tx_b, en_b} !== {3'd3, 1'b0, 1'b0}) begin
      n_miss++;
      $display("FAIL t3_retry_wait: got %b expected %b", {state_b, tx_b, en_b}, {3'd3, 1'b0, 1'b0});
    end
    tick();
    n_vec++;
    if ({state_b, en_b} !== {3'd3, 1'b1}) begin
      n_miss++;
      $display("FAIL t3_retry_timer: got %b expected %b", {state_b, en_b}, {3'd3, 1'b1});
    end
    timeout_b = 1'b1; tick(); timeout_b = 1'b0;
    n_vec++;
    if ({state_b, tx_b, en_b} !== {3'd1, 1'b1, 1'b0}) begin
      n_miss++;
      $display("FAIL t3_second_req: got %b expected %b", {state_b, tx_b, en_b}, {3'd1, 1'b1, 1'b0});
    end
    tick();
    phy_b = 4'hF; rx_b = {3'b000, 3'b000, 3'b011, 3'b011}; tick();
    phy_b = 4'h0; rx_b = 12'h000;
    n_vec++;
    if ({state_b, done_b, lanes_b} !== {3'd4, 1'b1, 4'b0011}) begin
      n_miss++;
      $display("FAIL t3_match_polling: got %b expected %b", {state_b, done_b, lanes_b}, {3'd4, 1'b1, 4'b0011});
    end
    restart_b = 1'b1; tick(); restart_b = 1'b0;
    n_vec++;
    if ({state_b, done_b, lanes_b} !== {3'd0, 1'b0, 4'b0000}) begin
      n_miss++;
      $display("FAIL t3_restart: got %b expected %b", {state_b, done_b, lanes_b}, {3'd0, 1'b0, 4'b0000});
    end
    tick();
    timeout_b = 1'b1; tick(); timeout_b = 1'b0;
    tick();
    phy_b = 4'hF; rx_b = {3'b000, 3'b000, 3'b011, 3'b011}; tick();
    phy_b = 4'h0; rx_b = 12'h000;
    n_vec++;
    if (state_b !== 3'd3) begin
      n_miss++;
      $display("FAIL t3_retry_again: got %0d expected %0d", state_b, 3);
    end
    tick();
    timeout_b = 1'b1; tick(); timeout_b = 1'b0;
    tick();
    phy_b = 4'hF; rx_b = {3'b000, 3'b000, 3'b000, 3'b011}; tick();
    phy_b = 4'h0; rx_b = 12'h000;
    n_vec++;
    if ({state_b, done_b, lanes_b, tx_b} !== {3'd0, 1'b0, 4'b0000, 1'b0}) begin
      n_miss++;
      $display("FAIL t3_mismatch_quiet: got %b expected %b", {state_b, done_b, lanes_b, tx_b},
               {3'd0, 1'b0, 4'b0000, 1'b0});
    end
  endtask

  task automatic test_eidle_exit();
    eidle_a = 1'b0; tick(); tick(); eidle_a = 1'b1; tick();
`ifdef LTSSM_EIDLE_EXIT_EN
    n_vec++;
    if ({state_a, tx_a} !== {3'd1, 1'b1}) begin
      n_miss++;
      $display("FAIL t6_eidle_exit: got %b expected %b", {state_a, tx_a}, {3'd1, 1'b1});
    end
`else
    n_vec++;
    if ({state_a, en_a, tx_a} !== {3'd0, 1'b1, 1'b0}) begin
      n_miss++;
      $display("FAIL t6_eidle_ignored: got %b expected %b", {state_a, en_a, tx_a}, {3'd0, 1'b1, 1'b0});
    end
    timeout_a = 1'b1; tick(); timeout_a = 1'b0;
    n_vec++;
    if ({state_a, tx_a} !== {3'd1, 1'b1}) begin
      n_miss++;
      $display("FAIL t6_timeout_exit: got %b expected %b", {state_a, tx_a}, {3'd1, 1'b1});
    end
`endif
  endtask

  initial begin
    test_reset();
    test_detect_present();
    test_detect_absent();
    test_resp_timeout();
    test_link_drop();
    test_multilane();
    test_eidle_exit();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ltssm_detect.md
Name: ltssm_detect

Overview:
- LTSSM Detect sub-state machine; the direct consumer of the 12 ms detect timer.
- Drives the timer enable and consumes its timeout pulse.
- Sequences PIPE receiver detection (Detect.Quiet -> Detect.Active, with one retry) and hands off to Polling with a lane-detected mask.
- Sits between the detect timer and the top-level LTSSM / PIPE MAC interface.

Parameters:
- NUM_LANES, 1, number of PIPE lanes handled.
- RESP_TIMEOUT_CYCLES, 1024, maximum cycles to wait for all phy_status_i responses before treating the attempt as "no receiver".

Ports:
- clk_i  input  1  clock, 200 MHz.
- rst_i  input  1  reset, asynchronous, active-high.
- link_en_i  input  1  1 = run detect; 0 = hold in QUIET with timer disabled.
- restart_i  input  1  one-cycle pulse; returns the FSM from POLLING to QUIET.
- timeout_i  input  1  one-cycle timeout pulse from the detect timer.
- phy_status_i  input  NUM_LANES  PIPE PhyStatus, one pulse per lane per detect request.
- rx_status_i  input  3*NUM_LANES  PIPE RxStatus per lane; 3'b011 = receiver present.
- rx_elec_idle_i  input  NUM_LANES  PIPE RxElecIdle.
- en_timer_o  output  1  enable to the detect timer.
- tx_detect_rx_o  output  1  PIPE TxDetectRx/Loopback.
- tx_elec_idle_o  output  1  PIPE TxElecIdle.
- power_down_o  output  2  PIPE PowerDown; P1 = 2'b10.
- lanes_detected_o  output  NUM_LANES  final detected-lane mask; valid while detect_done_o = 1.
- detect_done_o  output  1  level; 1 while in POLLING.
- state_o  output  3  current state encoding.

Behaviour:
- Reset values: state QUIET; en_timer_o = 0, tx_detect_rx_o = 0, tx_elec_idle_o = 1, power_down_o = 2'b10, lanes_detected_o = 0, detect_done_o = 0.
- All outputs are registered.
- The timer free-runs while enabled and clears when disabled; its timeout is a single-cycle pulse.
  - Every timed wait therefore starts with en_timer_o = 0 for at least one cycle (the state entry cycle), then 1.
  - timeout_i is honoured only when en_timer_o = 1 in the same cycle.
- States and transitions:
  - QUIET:
    - en_timer_o = link_en_i, registered, after the 1-cycle clear.
    - On timeout_i -> ACT_REQ.
    - If link_en_i = 0: stay, timer held off.
  - ACT_REQ:
    - Assert tx_detect_rx_o; clear per-lane response/result flags; load the response counter.
    - Next cycle -> ACT_WAIT.
  - ACT_WAIT:
    - Hold tx_detect_rx_o = 1.
    - Per lane: on phy_status_i[l], set resp[l] and det[l] = (rx_status lane l == 3'b011).
    - When resp is all ones, or the counter expires: deassert tx_detect_rx_o. Lanes that never responded count as det = 0.
    - Then:
      - det all ones -> POLLING.
      - det all zeros -> QUIET.
      - otherwise, on the first attempt -> RETRY_WAIT, latching the first mask.
    - Second attempt:
      - det == first mask -> POLLING.
      - det != first mask -> QUIET.
  - RETRY_WAIT:
    - 12 ms wait: timer cleared 1 cycle, then enabled.
    - On timeout_i -> ACT_REQ, marked as the second attempt.
  - POLLING:
    - detect_done_o = 1; lanes_detected_o = det mask.
    - tx_elec_idle_o stays 1; the top level takes over.
    - On restart_i -> QUIET, clearing the mask and done.
- Boundary conditions:
  - link_en_i falling in any state other than POLLING: next cycle -> QUIET with tx_detect_rx_o = 0 and timer off.
  - phy_status_i arriving outside ACT_WAIT: ignored.
  - A duplicate phy_status_i on an already-responded lane: ignored (first response wins).
  - phy_status_i and counter expiry in the same cycle: the response is counted.
  - NUM_LANES = 1: a partial result is impossible, so RETRY_WAIT is unreachable.
  - Response counter width: $clog2(RESP_TIMEOUT_CYCLES+1).

Optional Feature:
- Macro: LTSSM_EIDLE_EXIT_EN.
- Defined: in QUIET, any lane with rx_elec_idle_i = 0 for 2 consecutive cycles (2-flop-filtered) exits to ACT_REQ without waiting for timeout_i.
- Not defined: rx_elec_idle_i is ignored and QUIET exits only on timeout_i.

Decomposition:
- Package ltssm_pkg holds:
  - typedef enum for the detect states (QUIET, ACT_REQ, ACT_WAIT, RETRY_WAIT, POLLING).
  - Constants RXSTAT_RX_PRESENT = 3'b011 and PD_P1 = 2'b10.
- Sub-module ltssm_lane_resp: per-lane response/detect flag capture, instantiated NUM_LANES times.

Test Plan:
1. NUM_LANES=1, link_en_i=1, timeout after N cycles; PHY answers rx_status=3'b011 three cycles after tx_detect_rx_o -> POLLING, detect_done_o=1, lanes_detected_o=1'b1, en_timer_o low for 1 cycle on QUIET entry.
2. Single lane, rx_status=3'b000 -> back to QUIET; en_timer_o drops for 1 cycle then re-enables; second timeout triggers a new ACT_REQ.
3. NUM_LANES=4, first detect mask 4'b0011 -> RETRY_WAIT; after timeout the second mask 4'b0011 -> POLLING with lanes_detected_o=4'b0011. Repeat with second mask 4'b0001 -> QUIET.
4. No phy_status_i at all -> after RESP_TIMEOUT_CYCLES=1024 cycles tx_detect_rx_o=0 and state QUIET.
5. link_en_i dropped mid ACT_WAIT -> next cycle QUIET, tx_detect_rx_o=0, en_timer_o=0; a late phy_status_i is ignored.
6. With LTSSM_EIDLE_EXIT_EN defined: rx_elec_idle_i[0]=0 for 2 cycles in QUIET -> ACT_REQ before timeout. Without the macro: no exit until timeout_i.
